// File: rtl/tb_test_monitor.sv
// End-of-test monitor: snoops register write-back, tracks end/pass/test-number
// shadows and reports pass, fail or timeout after a settle window.
module tb_test_monitor #(
  parameter int XLEN           = 32,
  parameter int END_REG        = 26,
  parameter int PASS_REG       = 27,
  parameter int TNUM_REG       = 3,
  parameter int SETTLE_CYCLES  = 15,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int CNT_W          = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wb_en,
  input  logic [4:0]       wb_addr,
  input  logic [XLEN-1:0]  wb_data,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic             timeout,
  output logic [XLEN-1:0]  fail_tnum,
  output logic [CNT_W-1:0] cycles
);

  localparam int SET_W =
    (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  localparam logic [XLEN-1:0] ONE =
    {{(XLEN-1){1'b0}}, 1'b1};

  localparam logic [SET_W-1:0] SET_LOAD =
    SET_W'(SETTLE_CYCLES - 1);

  localparam logic [CNT_W-1:0] TO_LAST =
    CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_RUN,
    S_SETTLE,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [XLEN-1:0]  sh_end_q, sh_end_d;
  logic [XLEN-1:0]  sh_pass_q, sh_pass_d;
  logic [XLEN-1:0]  sh_tnum_q, sh_tnum_d;
  logic [SET_W-1:0] settle_q, settle_d;
  logic [CNT_W-1:0] cycles_q, cycles_d;
  logic [CNT_W-1:0] cycles_inc;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic             fail_q, fail_d;
  logic             timeout_q, timeout_d;
  logic [XLEN-1:0]  tnum_q, tnum_d;

  logic wr_end, wr_pass, wr_tnum, end_hit;

  assign wr_end  = wb_en && (wb_addr == 5'(END_REG));
  assign wr_pass = wb_en && (wb_addr == 5'(PASS_REG));
  assign wr_tnum = wb_en && (wb_addr == 5'(TNUM_REG));

  assign end_hit = (wr_end && (wb_data == ONE))
                || (sh_end_q == ONE);

  assign cycles_inc = (cycles_q == '1)
                    ? cycles_q
                    : cycles_q + CNT_W'(1);

  always_comb begin
    state_d   = state_q;
    sh_end_d  = sh_end_q;
    sh_pass_d = sh_pass_q;
    sh_tnum_d = sh_tnum_q;
    settle_d  = settle_q;
    cycles_d  = cycles_q;
    done_d    = done_q;
    pass_d    = pass_q;
    fail_d    = fail_q;
    timeout_d = timeout_q;
    tnum_d    = tnum_q;

    // Shadows track write-back until the verdict is frozen
    if (state_q != S_DONE) begin
      if (wr_end)  sh_end_d  = wb_data;
      if (wr_pass) sh_pass_d = wb_data;
      if (wr_tnum) sh_tnum_d = wb_data;
    end

    unique case (state_q)
      S_RUN: begin
        cycles_d = cycles_inc;
        if (end_hit) begin
          state_d  = S_SETTLE;
          settle_d = SET_LOAD;
        end else if (cycles_q == TO_LAST) begin
          state_d   = S_DONE;
          done_d    = 1'b1;
          timeout_d = 1'b1;
          tnum_d    = sh_tnum_q;
        end
      end
      S_SETTLE: begin
        cycles_d = cycles_inc;
        if (settle_q == '0) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          pass_d  = (sh_pass_d == ONE);
          fail_d  = (sh_pass_d != ONE);
          tnum_d  = sh_tnum_d;
        end else begin
          settle_d = settle_q - SET_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_DONE;
      end
      default: begin
        state_d = S_RUN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_RUN;
      sh_end_q  <= '0;
      sh_pass_q <= '0;
      sh_tnum_q <= '0;
      settle_q  <= '0;
      cycles_q  <= '0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      fail_q    <= 1'b0;
      timeout_q <= 1'b0;
      tnum_q    <= '0;
    end else begin
      state_q   <= state_d;
      sh_end_q  <= sh_end_d;
      sh_pass_q <= sh_pass_d;
      sh_tnum_q <= sh_tnum_d;
      settle_q  <= settle_d;
      cycles_q  <= cycles_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      fail_q    <= fail_d;
      timeout_q <= timeout_d;
      tnum_q    <= tnum_d;
    end
  end

  assign done      = done_q;
  assign pass      = pass_q;
  assign fail      = fail_q;
  assign timeout   = timeout_q;
  assign fail_tnum = tnum_q;
  assign cycles    = cycles_q;

endmodule

// File: tb/tb_tb_test_monitor.sv
// Directed bench for the end-of-test monitor (TIMEOUT_CYCLES=100).
module tb_tb_test_monitor;

  logic        clk;
  logic        rst;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        done;
  logic        pass;
  logic        fail;
  logic        timeout;
  logic [31:0] fail_tnum;
  logic [31:0] cycles;

  int n_chk;
  int n_fail;
  int tb_cyc;

  tb_test_monitor #(
    .XLEN(32),
    .END_REG(26),
    .PASS_REG(27),
    .TNUM_REG(3),
    .SETTLE_CYCLES(15),
    .TIMEOUT_CYCLES(100),
    .CNT_W(32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .wb_en(wb_en),
    .wb_addr(wb_addr),
    .wb_data(wb_data),
    .done(done),
    .pass(pass),
    .fail(fail),
    .timeout(timeout),
    .fail_tnum(fail_tnum),
    .cycles(cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    rst     = 1'b0;
    wb_en   = 1'b0;
    wb_addr = '0;
    wb_data = '0;
    repeat (2) @(negedge clk);
    rst    = 1'b1;
    tb_cyc = 0;
  endtask

  // Drive one cycle (cycle index tb_cyc), sample 1ns after its closing edge
  task automatic step(input logic en, input logic [4:0] a,
                      input logic [31:0] d);
    wb_en   = en;
    wb_addr = a;
    wb_data = d;
    @(posedge clk);
    #1;
    tb_cyc++;
    wb_en   = 1'b0;
    wb_addr = '0;
    wb_data = '0;
  endtask

  task automatic idle_to(input int n);
    while (tb_cyc < n) step(1'b0, 5'd0, 32'd0);
  endtask

  task automatic test_reset();
    rst     = 1'b0;
    wb_en   = 1'b0;
    wb_addr = '0;
    wb_data = '0;
    #12;
    n_chk++;
    if ({done, pass, fail, timeout} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b want 0000",
               {done, pass, fail, timeout});
    end
    n_chk++;
    if (fail_tnum !== 32'd0 || cycles !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_regs: tnum=%0d cyc=%0d want 0 0",
               fail_tnum, cycles);
    end
  endtask

  task automatic test_pass();
    do_reset();
    idle_to(10);
    step(1'b1, 5'd27, 32'd1);
    idle_to(20);
    step(1'b1, 5'd26, 32'd1);
    idle_to(25);
    step(1'b1, 5'd26, 32'd0);
    idle_to(35);
    n_chk++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL pass_early: done=%b want 0", done);
    end
    step(1'b0, 5'd0, 32'd0);
    n_chk++;
    if ({done, pass, fail, timeout} !== 4'b1100) begin
      n_fail++;
      $display("FAIL pass_verdict: got %b want 1100",
               {done, pass, fail, timeout});
    end
    n_chk++;
    if (cycles !== 32'd36) begin
      n_fail++;
      $display("FAIL pass_cycles: got %0d want 36", cycles);
    end
    step(1'b1, 5'd27, 32'd0);
    step(1'b1, 5'd3, 32'd5);
    idle_to(45);
    n_chk++;
    if ({done, pass, fail, timeout} !== 4'b1100
        || cycles !== 32'd36 || fail_tnum !== 32'd0) begin
      n_fail++;
      $display("FAIL done_frozen: got %b cyc=%0d tnum=%0d want 1100 36 0",
               {done, pass, fail, timeout}, cycles, fail_tnum);
    end
  endtask

  task automatic test_fail();
    do_reset();
    step(1'b1, 5'd3, 32'd7);
    idle_to(4);
    step(1'b1, 5'd26, 32'd1);
    idle_to(20);
    n_chk++;
    if ({done, pass, fail, timeout} !== 4'b1010) begin
      n_fail++;
      $display("FAIL fail_verdict: got %b want 1010",
               {done, pass, fail, timeout});
    end
    n_chk++;
    if (fail_tnum !== 32'd7) begin
      n_fail++;
      $display("FAIL fail_tnum: got %0d want 7", fail_tnum);
    end
  endtask

  task automatic test_late_pass();
    do_reset();
    idle_to(5);
    step(1'b1, 5'd26, 32'd1);
    idle_to(8);
    step(1'b1, 5'd3, 32'd4);
    idle_to(12);
    step(1'b1, 5'd27, 32'd1);
    idle_to(21);
    n_chk++;
    if ({done, pass, fail} !== 3'b110 || fail_tnum !== 32'd4) begin
      n_fail++;
      $display("FAIL late_pass: got %b tnum=%0d want 110 4",
               {done, pass, fail}, fail_tnum);
    end
    step(1'b1, 5'd3, 32'd9);
    n_chk++;
    if (fail_tnum !== 32'd4) begin
      n_fail++;
      $display("FAIL late_tnum_ignored: got %0d want 4", fail_tnum);
    end
    // Write on the very edge that enters DONE still counts
    do_reset();
    idle_to(5);
    step(1'b1, 5'd26, 32'd1);
    idle_to(20);
    step(1'b1, 5'd27, 32'd1);
    n_chk++;
    if ({done, pass, fail} !== 3'b110) begin
      n_fail++;
      $display("FAIL last_settle_write: got %b want 110",
               {done, pass, fail});
    end
    // One cycle later it is too late
    do_reset();
    idle_to(5);
    step(1'b1, 5'd26, 32'd1);
    idle_to(21);
    step(1'b1, 5'd27, 32'd1);
    n_chk++;
    if ({done, pass, fail} !== 3'b101) begin
      n_fail++;
      $display("FAIL after_window_write: got %b want 101",
               {done, pass, fail});
    end
  endtask

  task automatic test_timeout();
    do_reset();
    step(1'b1, 5'd3, 32'd11);
    idle_to(99);
    n_chk++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_early: done=%b want 0", done);
    end
    step(1'b0, 5'd0, 32'd0);
    n_chk++;
    if ({done, pass, fail, timeout} !== 4'b1001
        || fail_tnum !== 32'd11) begin
      n_fail++;
      $display("FAIL timeout_verdict: got %b tnum=%0d want 1001 11",
               {done, pass, fail, timeout}, fail_tnum);
    end
    do_reset();
    idle_to(99);
    step(1'b1, 5'd26, 32'd1);
    n_chk++;
    if (done !== 1'b0 || timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL end_beats_timeout: done=%b to=%b want 0 0",
               done, timeout);
    end
    idle_to(114);
    n_chk++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL settle_no_timeout: done=%b want 0", done);
    end
    step(1'b0, 5'd0, 32'd0);
    n_chk++;
    if ({done, pass, fail, timeout} !== 4'b1010) begin
      n_fail++;
      $display("FAIL settle_verdict: got %b want 1010",
               {done, pass, fail, timeout});
    end
  endtask

  task automatic test_x0_nonone();
    do_reset();
    step(1'b1, 5'd0, 32'd1);
    step(1'b1, 5'd26, 32'd2);
    step(1'b1, 5'd26, 32'd3);
    idle_to(100);
    n_chk++;
    if ({done, pass, fail, timeout} !== 4'b1001) begin
      n_fail++;
      $display("FAIL nonone_timeout: got %b want 1001",
               {done, pass, fail, timeout});
    end
    do_reset();
    step(1'b1, 5'd26, 32'd3);
    idle_to(50);
    step(1'b1, 5'd26, 32'd1);
    idle_to(65);
    n_chk++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL one_after_nonone_early: done=%b want 0", done);
    end
    step(1'b0, 5'd0, 32'd0);
    n_chk++;
    if ({done, pass, fail, timeout} !== 4'b1010) begin
      n_fail++;
      $display("FAIL one_after_nonone: got %b want 1010",
               {done, pass, fail, timeout});
    end
  endtask

  task automatic test_reset_mid_settle();
    do_reset();
    step(1'b1, 5'd3, 32'd6);
    idle_to(10);
    step(1'b1, 5'd27, 32'd1);
    idle_to(20);
    step(1'b1, 5'd26, 32'd1);
    idle_to(25);
    #2;
    rst = 1'b0;
    #1;
    n_chk++;
    if ({done, pass, fail, timeout} !== 4'b0000
        || fail_tnum !== 32'd0 || cycles !== 32'd0) begin
      n_fail++;
      $display("FAIL async_reset: got %b tnum=%0d cyc=%0d want 0000 0 0",
               {done, pass, fail, timeout}, fail_tnum, cycles);
    end
    @(negedge clk);
    rst    = 1'b1;
    tb_cyc = 0;
    step(1'b1, 5'd27, 32'd1);
    idle_to(3);
    step(1'b1, 5'd26, 32'd1);
    idle_to(18);
    n_chk++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL restart_early: done=%b want 0", done);
    end
    step(1'b0, 5'd0, 32'd0);
    n_chk++;
    if ({done, pass, fail, timeout} !== 4'b1100
        || cycles !== 32'd19 || fail_tnum !== 32'd0) begin
      n_fail++;
      $display("FAIL restart_pass: got %b cyc=%0d tnum=%0d want 1100 19 0",
               {done, pass, fail, timeout}, cycles, fail_tnum);
    end
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    tb_cyc = 0;
    test_reset();
    test_pass();
    test_fail();
    test_late_pass();
    test_timeout();
    test_x0_nonone();
    test_reset_mid_settle();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
